// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - memory instruction port, redirect and decode handshake bundle
interface instruction_fetch_unit_if #(
  parameter int DEPTH = 4
);
  logic                     fetch_enable;
  logic [11:0]              Instruction_addressbus;
  logic [15:0]              Instruction_databus;
  logic                     redirect_valid;
  logic [11:0]              redirect_addr;
  logic                     instr_valid;
  logic                     instr_ready;
  logic [15:0]              instr_data;
  logic [11:0]              instr_pc;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport master (
    input  fetch_enable,
    output Instruction_addressbus,
    input  Instruction_databus,
    input  redirect_valid,
    input  redirect_addr,
    output instr_valid,
    input  instr_ready,
    output instr_data,
    output instr_pc,
    output fifo_count
  );

  modport slave (
    output fetch_enable,
    input  Instruction_addressbus,
    output Instruction_databus,
    output redirect_valid,
    output redirect_addr,
    input  instr_valid,
    output instr_ready,
    input  instr_data,
    input  instr_pc,
    input  fifo_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, JMP folding and instruction buffer feeding decode
module instruction_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [11:0] RESET_PC = 12'h000,
  parameter bit          FOLD_JMP = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  instruction_fetch_unit_if.master   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [11:0]   pc;
  logic [11:0]   pc_next;
  logic [15:0]   data_mem [DEPTH];
  logic [11:0]   addr_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          jmp_fold;
  logic          pop;
  logic          push;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign jmp_fold = FOLD_JMP && (bus.Instruction_databus[15:12] == 4'hF);
  assign pop      = !empty && bus.instr_ready;
  assign push     = bus.fetch_enable && !bus.redirect_valid && (!full || pop) && !jmp_fold;

  // A folded JMP redirects fetch even when the buffer is full, since nothing is pushed.
  always_comb begin
    pc_next = pc;
    if (bus.redirect_valid)
      pc_next = {bus.redirect_addr[11:1], 1'b0};
    else if (bus.fetch_enable && jmp_fold)
      pc_next = {bus.Instruction_databus[10:0], 1'b0};
    else if (push)
      pc_next = pc + 12'd2;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc     <= {RESET_PC[11:1], 1'b0};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      pc <= pc_next;
      if (bus.redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)
          count <= count + 1'b1;
        else if (pop && !push)
          count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      data_mem[wr_ptr] <= bus.Instruction_databus;
      addr_mem[wr_ptr] <= pc;
    end
  end

  assign bus.Instruction_addressbus = pc;
  assign bus.instr_valid            = !empty;
  assign bus.instr_data             = empty ? 16'h0000 : data_mem[rd_ptr];
  assign bus.instr_pc               = empty ? 12'h000 : addr_mem[rd_ptr];
  assign bus.fifo_count             = count;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [15:0] mem0 [2048];
  logic [15:0] mem1 [2048];
  logic [15:0] mem2 [2048];

  instruction_fetch_unit_if #(.DEPTH(4)) b0 ();
  instruction_fetch_unit_if #(.DEPTH(4)) b1 ();
  instruction_fetch_unit_if #(.DEPTH(4)) b2 ();

  instruction_fetch_unit #(.DEPTH(4), .RESET_PC(12'h000), .FOLD_JMP(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  instruction_fetch_unit #(.DEPTH(4), .RESET_PC(12'hFFE), .FOLD_JMP(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  instruction_fetch_unit #(.DEPTH(4), .RESET_PC(12'h000), .FOLD_JMP(1'b0)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  assign b0.Instruction_databus = mem0[b0.Instruction_addressbus[11:1]];
  assign b1.Instruction_databus = mem1[b1.Instruction_addressbus[11:1]];
  assign b2.Instruction_databus = mem2[b2.Instruction_addressbus[11:1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    checks++; if (b0.Instruction_addressbus !== 12'h000) begin errors++; $display("FAIL reset_addr got %h expected 000", b0.Instruction_addressbus); end
    checks++; if (b0.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", b0.fifo_count); end
    checks++; if (b0.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", b0.instr_valid); end
    checks++; if (b0.instr_data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h expected 0000", b0.instr_data); end
    checks++; if (b0.instr_pc !== 12'h000) begin errors++; $display("FAIL reset_pc got %h expected 000", b0.instr_pc); end
    checks++; if (b1.Instruction_addressbus !== 12'hFFE) begin errors++; $display("FAIL reset_pc_param got %h expected ffe", b1.Instruction_addressbus); end
  endtask

  task automatic test_fold();
    b0.fetch_enable = 1'b1;
    b0.instr_ready  = 1'b1;
    step();
    checks++; if (b0.Instruction_addressbus !== 12'h190) begin errors++; $display("FAIL fold_target got %h expected 190", b0.Instruction_addressbus); end
    checks++; if (b0.fifo_count !== 3'd0) begin errors++; $display("FAIL fold_nopush got %0d expected 0", b0.fifo_count); end
    step();
    checks++; if (b0.instr_valid !== 1'b1) begin errors++; $display("FAIL fold_valid got %b expected 1", b0.instr_valid); end
    checks++; if (b0.instr_data !== 16'h0688) begin errors++; $display("FAIL fold_data got %h expected 0688", b0.instr_data); end
    checks++; if (b0.instr_pc !== 12'h190) begin errors++; $display("FAIL fold_pc got %h expected 190", b0.instr_pc); end
    checks++; if (b0.Instruction_addressbus !== 12'h192) begin errors++; $display("FAIL fold_next_addr got %h expected 192", b0.Instruction_addressbus); end
    b0.instr_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    step();
    step();
    step();
    checks++; if (b0.fifo_count !== 3'd4) begin errors++; $display("FAIL bp_count got %0d expected 4", b0.fifo_count); end
    checks++; if (b0.Instruction_addressbus !== 12'h198) begin errors++; $display("FAIL bp_addr got %h expected 198", b0.Instruction_addressbus); end
    step();
    checks++; if (b0.fifo_count !== 3'd4) begin errors++; $display("FAIL bp_hold_count got %0d expected 4", b0.fifo_count); end
    checks++; if (b0.Instruction_addressbus !== 12'h198) begin errors++; $display("FAIL bp_hold_addr got %h expected 198", b0.Instruction_addressbus); end
  endtask

  task automatic test_full_push_pop();
    logic [11:0] exp_pc;
    logic [11:0] exp_addr;
    logic [15:0] exp_data;
    b0.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_pc   = 12'h190 + 12'(2 * i);
      exp_addr = 12'h198 + 12'(2 * i);
      exp_data = (i == 0) ? 16'h0688 : 16'hD000;
      checks++; if (b0.instr_pc !== exp_pc) begin errors++; $display("FAIL pp_pc[%0d] got %h expected %h", i, b0.instr_pc, exp_pc); end
      checks++; if (b0.instr_data !== exp_data) begin errors++; $display("FAIL pp_data[%0d] got %h expected %h", i, b0.instr_data, exp_data); end
      checks++; if (b0.fifo_count !== 3'd4) begin errors++; $display("FAIL pp_count[%0d] got %0d expected 4", i, b0.fifo_count); end
      checks++; if (b0.Instruction_addressbus !== exp_addr) begin errors++; $display("FAIL pp_addr[%0d] got %h expected %h", i, b0.Instruction_addressbus, exp_addr); end
      step();
    end
    checks++; if (b0.instr_pc !== 12'h198) begin errors++; $display("FAIL pp_resume_pc got %h expected 198", b0.instr_pc); end
    checks++; if (b0.Instruction_addressbus !== 12'h1A0) begin errors++; $display("FAIL pp_resume_addr got %h expected 1a0", b0.Instruction_addressbus); end
  endtask

  task automatic test_redirect();
    b0.fetch_enable = 1'b0;
    b0.instr_ready  = 1'b1;
    step();
    checks++; if (b0.fifo_count !== 3'd3) begin errors++; $display("FAIL rd_pre_count got %0d expected 3", b0.fifo_count); end
    b0.fetch_enable   = 1'b1;
    b0.redirect_valid = 1'b1;
    b0.redirect_addr  = 12'h0C9;
    step();
    b0.redirect_valid = 1'b0;
    b0.instr_ready    = 1'b0;
    checks++; if (b0.fifo_count !== 3'd0) begin errors++; $display("FAIL rd_count got %0d expected 0", b0.fifo_count); end
    checks++; if (b0.instr_valid !== 1'b0) begin errors++; $display("FAIL rd_valid got %b expected 0", b0.instr_valid); end
    checks++; if (b0.Instruction_addressbus !== 12'h0C8) begin errors++; $display("FAIL rd_addr got %h expected 0c8", b0.Instruction_addressbus); end
    checks++; if (b0.instr_data !== 16'h0000) begin errors++; $display("FAIL rd_data got %h expected 0000", b0.instr_data); end
    step();
    checks++; if (b0.fifo_count !== 3'd1) begin errors++; $display("FAIL rd_refill_count got %0d expected 1", b0.fifo_count); end
    checks++; if (b0.instr_pc !== 12'h0C8) begin errors++; $display("FAIL rd_refill_pc got %h expected 0c8", b0.instr_pc); end
  endtask

  task automatic test_wrap();
    b1.fetch_enable = 1'b1;
    checks++; if (b1.Instruction_addressbus !== 12'hFFE) begin errors++; $display("FAIL wrap_start got %h expected ffe", b1.Instruction_addressbus); end
    step();
    b1.fetch_enable = 1'b0;
    checks++; if (b1.fifo_count !== 3'd1) begin errors++; $display("FAIL wrap_count got %0d expected 1", b1.fifo_count); end
    checks++; if (b1.instr_pc !== 12'hFFE) begin errors++; $display("FAIL wrap_pc got %h expected ffe", b1.instr_pc); end
    checks++; if (b1.instr_data !== 16'h0688) begin errors++; $display("FAIL wrap_data got %h expected 0688", b1.instr_data); end
    checks++; if (b1.Instruction_addressbus !== 12'h000) begin errors++; $display("FAIL wrap_addr got %h expected 000", b1.Instruction_addressbus); end
  endtask

  task automatic test_nofold_enable();
    b2.fetch_enable = 1'b1;
    step();
    b2.fetch_enable = 1'b0;
    checks++; if (b2.instr_data !== 16'hF0C8) begin errors++; $display("FAIL nf_data got %h expected f0c8", b2.instr_data); end
    checks++; if (b2.instr_pc !== 12'h000) begin errors++; $display("FAIL nf_pc got %h expected 000", b2.instr_pc); end
    checks++; if (b2.Instruction_addressbus !== 12'h002) begin errors++; $display("FAIL nf_addr got %h expected 002", b2.Instruction_addressbus); end
    step();
    step();
    checks++; if (b2.Instruction_addressbus !== 12'h002) begin errors++; $display("FAIL en_hold_addr got %h expected 002", b2.Instruction_addressbus); end
    checks++; if (b2.fifo_count !== 3'd1) begin errors++; $display("FAIL en_hold_count got %0d expected 1", b2.fifo_count); end
    b2.fetch_enable = 1'b1;
    step();
    b2.fetch_enable = 1'b0;
    checks++; if (b2.fifo_count !== 3'd2) begin errors++; $display("FAIL en_resume_count got %0d expected 2", b2.fifo_count); end
    checks++; if (b2.Instruction_addressbus !== 12'h004) begin errors++; $display("FAIL en_resume_addr got %h expected 004", b2.Instruction_addressbus); end
  endtask

  task automatic test_reset_midop();
    b0.fetch_enable   = 1'b1;
    b0.instr_ready    = 1'b1;
    b0.redirect_valid = 1'b1;
    b0.redirect_addr  = 12'h100;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    b0.redirect_valid = 1'b0;
    b0.fetch_enable   = 1'b0;
    checks++; if (b0.Instruction_addressbus !== 12'h000) begin errors++; $display("FAIL midrst_addr got %h expected 000", b0.Instruction_addressbus); end
    checks++; if (b0.fifo_count !== 3'd0) begin errors++; $display("FAIL midrst_count got %0d expected 0", b0.fifo_count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 2048; i++) begin
      mem0[i] = 16'hD000;
      mem1[i] = 16'hD000;
      mem2[i] = 16'hD000;
    end
    mem0[12'h000 >> 1] = 16'hF0C8;
    mem0[12'h190 >> 1] = 16'h0688;
    mem1[12'hFFE >> 1] = 16'h0688;
    mem2[12'h000 >> 1] = 16'hF0C8;
    b0.fetch_enable = 1'b0; b0.instr_ready = 1'b0; b0.redirect_valid = 1'b0; b0.redirect_addr = 12'h000;
    b1.fetch_enable = 1'b0; b1.instr_ready = 1'b0; b1.redirect_valid = 1'b0; b1.redirect_addr = 12'h000;
    b2.fetch_enable = 1'b0; b2.instr_ready = 1'b0; b2.redirect_valid = 1'b0; b2.redirect_addr = 12'h000;
    rst_n = 1'b0;
    #1;
    test_reset();
    test_fold();
    test_backpressure();
    test_full_push_pop();
    test_redirect();
    test_wrap();
    test_nofold_enable();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
